// File: rtl/gcd_lcm_coproc.sv
// Multi-cycle GCD/LCM coprocessor: binary Stein GCD, then LCM as (a/gcd)*b.
// Optional GCD_LCM_OVF_EN adds o_ovf, flagging nonzero upper lcm product bits.
module gcd_lcm_coproc #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_lcm_sel,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_busy,
`ifdef GCD_LCM_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_stall
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef GCD_LCM_OVF_EN
  localparam int ACCW = 2 * WIDTH;
`else
  localparam int ACCW = WIDTH;
`endif

  typedef enum logic [2:0] {S_IDLE, S_GCD, S_DIV, S_MUL, S_DONE} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a, r_b, r_u, r_v, r_g;
  logic              r_op;
  logic [CW-1:0]     r_k, r_cnt;
  logic [WIDTH-1:0]  r_rem, r_quo, r_mplier;
  logic [ACCW-1:0]   r_mcand, r_acc;
  logic [WIDTH-1:0]  r_result;
  logic              r_done, r_busy;
`ifdef GCD_LCM_OVF_EN
  logic              r_ovf;
`endif

  logic [WIDTH:0]    w_remShift, w_remSub;
  logic              w_fits;
  logic [WIDTH-1:0]  w_quoNext, w_gcdVal;
  logic [ACCW-1:0]   w_accNext;
  logic              w_last;

  // Restoring-division step, shift-add multiply step and Stein result shift.
  assign w_remShift = {r_rem, r_quo[WIDTH-1]};
  assign w_remSub   = w_remShift - {1'b0, r_g};
  assign w_fits     = (w_remShift >= {1'b0, r_g});
  assign w_quoNext  = {r_quo[WIDTH-2:0], w_fits};
  assign w_accNext  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_gcdVal   = r_u << r_k;
  assign w_last     = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_u      <= '0;
      r_v      <= '0;
      r_g      <= '0;
      r_op     <= 1'b0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef GCD_LCM_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a  <= i_src_a;
            r_b  <= i_src_b;
            r_op <= i_lcm_sel;
            r_u  <= i_src_a;
            r_v  <= i_src_b;
            r_k  <= '0;
            if (i_src_a == '0 || i_src_b == '0) begin
              // Zero operand short-circuit: gcd(0,x)=x, lcm(0,x)=0.
              r_result <= i_lcm_sel ? '0 : (i_src_a | i_src_b);
              r_done   <= 1'b1;
`ifdef GCD_LCM_OVF_EN
              r_ovf    <= 1'b0;
`endif
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_GCD;
            end
          end
        end
        S_GCD: begin
          if (r_u == r_v) begin
            if (!r_op) begin
              r_result <= w_gcdVal;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
`ifdef GCD_LCM_OVF_EN
              r_ovf    <= 1'b0;
`endif
              r_state  <= S_DONE;
            end else begin
              r_g     <= w_gcdVal;
              r_quo   <= r_a;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end
          end else if (!r_u[0] && !r_v[0]) begin
            r_u <= r_u >> 1;
            r_v <= r_v >> 1;
            r_k <= r_k + 1'b1;
          end else if (!r_u[0]) begin
            r_u <= r_u >> 1;
          end else if (!r_v[0]) begin
            r_v <= r_v >> 1;
          end else if (r_u > r_v) begin
            r_u <= r_u - r_v;
          end else begin
            r_v <= r_v - r_u;
          end
        end
        S_DIV: begin
          r_rem <= w_fits ? w_remSub[WIDTH-1:0] : w_remShift[WIDTH-1:0];
          r_quo <= w_quoNext;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_mcand  <= ACCW'(w_quoNext);
            r_mplier <= r_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_accNext[WIDTH-1:0];
`ifdef GCD_LCM_OVF_EN
            r_ovf    <= |w_accNext[ACCW-1:WIDTH];
`endif
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_done   = r_done;
  assign o_busy   = r_busy;
  assign o_stall  = (i_start && r_state == S_IDLE) || r_busy;
`ifdef GCD_LCM_OVF_EN
  assign o_ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Self-checking bench for gcd_lcm_coproc: vector table, corner sequences and random ops
// against a Euclid/arithmetic reference model. Honours GCD_LCM_OVF_EN when defined.
module tb_gcd_lcm_coproc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, lcmSel;
  logic [W-1:0] srcA, srcB;
  logic [W-1:0] result;
  logic         done, busy, stall;
`ifdef GCD_LCM_OVF_EN
  logic         ovf;
`endif

  int nChecks = 0;
  int nFails  = 0;

  gcd_lcm_coproc #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_lcm_sel (lcmSel),
    .i_src_a   (srcA),
    .i_src_b   (srcB),
    .o_result  (result),
    .o_done    (done),
    .o_busy    (busy),
`ifdef GCD_LCM_OVF_EN
    .o_ovf     (ovf),
`endif
    .o_stall   (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] expRes;
    logic         expOvf;
  } vec_t;

  // Reference model: Euclid by remainder, lcm from plain 64-bit arithmetic.
  function automatic logic [W-1:0] refGcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    if (x == 0) return y;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [2*W-1:0] refLcmFull(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] g;
    if (a == 0 || b == 0) return '0;
    g = refGcd(a, b);
    return (2*W)'(a / g) * (2*W)'(b);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one instruction and waits (bounded) for done; optionally scrambles inputs while busy.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                               input bit scramble, output logic [W-1:0] res, output logic ov,
                               output int lat, output bit stallOk, output bit doneOnce);
    @(negedge clk);
    srcA = a; srcB = b; lcmSel = sel; start = 1'b1;
    lat = 0; stallOk = 1'b1; res = '0; ov = 1'b0; doneOnce = 1'b0;
    #1;
    if (!stall) stallOk = 1'b0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!stall || !busy) stallOk = 1'b0;
      if (scramble) begin
        srcA = $urandom; srcB = $urandom; lcmSel = 1'($urandom);
      end
    end
    if (!done) lat = -1;
    res = result;
`ifdef GCD_LCM_OVF_EN
    ov = ovf;
`endif
    @(negedge clk);
    if (stall || busy) stallOk = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    doneOnce = !done && !busy;
  endtask

  task automatic runAndCheck(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sel, input bit scramble);
    logic [W-1:0]   res, expRes;
    logic           ov, expOvf;
    logic [2*W-1:0] full;
    int             lat, bound;
    bit             stallOk, doneOnce;
    if (sel) begin
      full   = refLcmFull(a, b);
      expRes = full[W-1:0];
      expOvf = (full[2*W-1:W] != 0);
    end else begin
      expRes = refGcd(a, b);
      expOvf = 1'b0;
    end
    applyStimulus(a, b, sel, scramble, res, ov, lat, stallOk, doneOnce);
    checkOutput({tag, " result"}, 64'(res), 64'(expRes));
`ifdef GCD_LCM_OVF_EN
    checkOutput({tag, " ovf"}, 64'(ov), 64'(expOvf));
`endif
    checkOutput({tag, " stall/busy"}, 64'(stallOk), 64'd1);
    checkOutput({tag, " single done"}, 64'(doneOnce), 64'd1);
    if (a == 0 || b == 0) begin
      checkOutput({tag, " zero latency"}, 64'(lat), 64'd1);
    end else begin
      bound = sel ? 6*W + 1 : 4*W + 1;
      checkOutput({tag, " latency in bound"}, 64'(lat >= 1 && lat <= bound), 64'd1);
    end
  endtask

  initial begin
    vec_t       vecs[$];
    logic [W-1:0] res;
    logic       ov;
    int         lat, latG, latL, cyc;
    bit         stallOk, doneOnce, sawDone;

    vecs.push_back('{32'd48,         32'd18,         1'b0, 32'd6,          1'b0});
    vecs.push_back('{32'd4,          32'd6,          1'b1, 32'd12,         1'b0});
    vecs.push_back('{32'd0,          32'd7,          1'b0, 32'd7,          1'b0});
    vecs.push_back('{32'd0,          32'd7,          1'b1, 32'd0,          1'b0});
    vecs.push_back('{32'd0,          32'd0,          1'b0, 32'd0,          1'b0});
    vecs.push_back('{32'd5,          32'd0,          1'b0, 32'd5,          1'b0});
    vecs.push_back('{32'hFFFFFFFF,   32'd1,          1'b0, 32'd1,          1'b0});
    vecs.push_back('{32'h00010000,   32'h00010001,   1'b1, 32'h00010000,   1'b1});
    vecs.push_back('{32'd3,          32'd5,          1'b1, 32'd15,         1'b0});
    vecs.push_back('{32'd1024,       32'd768,        1'b0, 32'd256,        1'b0});
    vecs.push_back('{32'd21,         32'd6,          1'b1, 32'd42,         1'b0});

    reset = 1'b1; start = 1'b0; lcmSel = 1'b0; srcA = '0; srcB = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset result", 64'(result), 64'd0);
    checkOutput("reset done",   64'(done),   64'd0);
    checkOutput("reset busy",   64'(busy),   64'd0);
    checkOutput("reset stall",  64'(stall),  64'd0);
    @(negedge clk); reset = 1'b0;

    // Table vectors: expected values written by hand from the arithmetic.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sel, 1'b0, res, ov, lat, stallOk, doneOnce);
      checkOutput($sformatf("vec%0d result", i), 64'(res), 64'(vecs[i].expRes));
`ifdef GCD_LCM_OVF_EN
      checkOutput($sformatf("vec%0d ovf", i), 64'(ov), 64'(vecs[i].expOvf));
`endif
      checkOutput($sformatf("vec%0d stall/busy", i), 64'(stallOk), 64'd1);
      checkOutput($sformatf("vec%0d single done", i), 64'(doneOnce), 64'd1);
      if (vecs[i].a == 0 || vecs[i].b == 0)
        checkOutput($sformatf("vec%0d zero latency", i), 64'(lat), 64'd1);
      else if (!vecs[i].sel)
        checkOutput($sformatf("vec%0d gcd latency bound", i), 64'(lat >= 1 && lat <= 4*W+1), 64'd1);
    end

    // lcm adds exactly 2*WIDTH cycles (DIV + MUL) on top of the gcd path.
    applyStimulus(32'd4, 32'd6, 1'b0, 1'b0, res, ov, latG, stallOk, doneOnce);
    applyStimulus(32'd4, 32'd6, 1'b1, 1'b0, res, ov, latL, stallOk, doneOnce);
    checkOutput("lcm extra latency", 64'(latL - latG), 64'(2*W));
    checkOutput("lcm(4,6) again", 64'(res), 64'd12);

    // Operand scrambling while busy must not disturb the result.
    runAndCheck("scramble gcd", 32'd48, 32'd18, 1'b0, 1'b1);
    runAndCheck("scramble lcm", 32'd9, 32'd12, 1'b1, 1'b1);

    // start held through DONE: the DONE cycle must not accept.
    @(negedge clk);
    srcA = 32'd48; srcB = 32'd18; lcmSel = 1'b0; start = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!done && cyc < 400);
    checkOutput("hold start done seen", 64'(done), 64'd1);
    @(posedge clk); #1;
    checkOutput("hold start no accept in DONE", 64'(busy), 64'd0);
    checkOutput("hold start stall in IDLE", 64'(stall), 64'd1);
    @(posedge clk); #1;
    checkOutput("hold start new accept", 64'(busy), 64'd1);
    @(negedge clk); start = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!done && cyc < 400);
    checkOutput("hold start second result", 64'(result), 64'd6);
    @(posedge clk); #1;

    // Reset while in DIV: abort to IDLE, clear result, no done.
    @(negedge clk);
    srcA = 32'h00010000; srcB = 32'h00010001; lcmSel = 1'b1; start = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk); reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    checkOutput("midDIV reset busy",   64'(busy),   64'd0);
    checkOutput("midDIV reset done",   64'(done),   64'd0);
    checkOutput("midDIV reset result", 64'(result), 64'd0);
    @(negedge clk); reset = 1'b0;
    sawDone = 1'b0;
    repeat (200) begin @(posedge clk); #1; if (done || busy) sawDone = 1'b1; end
    checkOutput("midDIV no done after reset", 64'(sawDone), 64'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 2000); b = $urandom_range(0, 2000); end
        2: begin a = $urandom_range(1, 300) * 64; b = $urandom_range(1, 300) * 48; end
        default: begin a = ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom; b = $urandom_range(0, 50); end
      endcase
      runAndCheck($sformatf("rand%0d", i), a, b, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
